// File: rtl/vga_pixel_probe_pkg.sv
// Game-side types for the pixel probe: probe directions (also the bit index
// into the hit vector), default background colour, FSM state encoding and
// the probe coordinate record.
package vga_pixel_probe_pkg;

  typedef enum logic [1:0] {
    PROBE_DOWN  = 2'd0,
    PROBE_UP    = 2'd1,
    PROBE_LEFT  = 2'd2,
    PROBE_RIGHT = 2'd3
  } probe_dir_e;

  localparam logic [11:0] BG_RGB_DEF = 12'h6AF;

  typedef logic [0:0] probe_state_t;
  localparam probe_state_t ST_WAIT_FRAME = 1'b0;
  localparam probe_state_t ST_SCAN       = 1'b1;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } probe_pt_t;

endpackage

// File: rtl/vga_pkg.sv
// Screen geometry of the active display area, shared by every block that
// taps the VGA pixel stream.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;

endpackage

// File: rtl/vga_pixel_probe_if.sv
// VGA pixel stream bundle.
//   hcount/vcount : current pixel coordinates
//   hblnk/vblnk   : horizontal / vertical blanking
//   rgb           : 12-bit pixel colour
// master drives the stream, slave and in are passive readers.
interface vga_if;

  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (output hcount, vcount, hblnk, vblnk, rgb);
  modport slave  (input  hcount, vcount, hblnk, vblnk, rgb);
  modport in     (input  hcount, vcount, hblnk, vblnk, rgb);

endinterface

// File: rtl/vga_point_sampler.sv
// One probe point: holds the coordinate latched at frame start, decides
// whether it lies off-screen and remembers whether the pixel seen there
// during the scan was solid.
//   latch       : load pt_next and clear the accumulator (frame start)
//   sample_en   : scan is running and the stream is in the active area
//   pixel_solid : current stream pixel differs from the background
//   result      : accumulated solidity, or EDGE_SOLID when off-screen
module vga_point_sampler
  import vga_pkg::*;
  import vga_pixel_probe_pkg::*;
#(
  parameter bit EDGE_SOLID = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        latch,
  input  logic        sample_en,
  input  logic        pixel_solid,
  input  probe_pt_t   pt_next,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  output logic        result
);

  probe_pt_t pt_q;
  logic      acc;
  logic      off_screen;
  logic      hit_here;

  // Underflowed coordinates wrap to large values and land here as well.
  assign off_screen = (pt_q.x >= 12'(HOR_PIXELS)) || (pt_q.y >= 12'(VER_PIXELS));

  assign hit_here = sample_en && !off_screen &&
                    ({1'b0, hcount} == pt_q.x) && ({1'b0, vcount} == pt_q.y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pt_q <= '0;
      acc  <= 1'b0;
    end else if (latch) begin
      pt_q <= pt_next;
      acc  <= 1'b0;
    end else if (hit_here) begin
      acc <= pixel_solid;
    end
  end

  assign result = off_screen ? EDGE_SOLID : acc;

endmodule

// File: rtl/vga_pixel_probe.sv
// Passive probe of the composited VGA stream (tapped upstream of the
// character sprite). Samples four points around the character each frame
// and reports per-point solidity through a valid/ready handshake.
//   pos_x/pos_y         : character centre
//   char_hgt/char_lng   : sprite half-height / half-width
//   vga_in              : pixel stream, read only
//   hit                 : [0]=down [1]=up [2]=left [3]=right, 1 = solid
//   hit_valid/hit_ready : result handshake
//   overrun             : an unaccepted result was overwritten
//
// state         | meaning
// ST_WAIT_FRAME | idle until the next frame start
// ST_SCAN       | sampling probe points until the vblnk rise
module vga_pixel_probe
  import vga_pkg::*;
  import vga_pixel_probe_pkg::*;
#(
  parameter logic [11:0] BG_RGB     = BG_RGB_DEF,
  parameter bit          EDGE_SOLID = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] pos_x,
  input  logic [11:0] pos_y,
  input  logic [11:0] char_hgt,
  input  logic [11:0] char_lng,
  vga_if.in           vga_in,
  output logic [3:0]  hit,
  output logic        hit_valid,
  input  logic        hit_ready,
  output logic        overrun
);

  probe_state_t    state;
  logic            vblnk_q;
  logic            frame_start;
  logic            frame_end;
  logic            publish;
  logic            sample_en;
  logic            pixel_solid;
  probe_pt_t [3:0] pts;
  logic [3:0]      res;

  assign frame_start = (vga_in.vcount == 11'd0) && (vga_in.hcount == 11'd0) &&
                       !vga_in.hblnk && !vga_in.vblnk;
  assign frame_end   = vga_in.vblnk && !vblnk_q;
  assign publish     = (state == ST_SCAN) && frame_end;
  assign sample_en   = (state == ST_SCAN) && !vga_in.hblnk && !vga_in.vblnk;
  assign pixel_solid = (vga_in.rgb != BG_RGB);

  // Probe coordinates wrap mod 4096; wrapped values fall off-screen.
  always_comb begin
    pts = '0;
    pts[PROBE_DOWN].x  = pos_x;
    pts[PROBE_DOWN].y  = pos_y + char_hgt;
    pts[PROBE_UP].x    = pos_x;
    pts[PROBE_UP].y    = pos_y - char_hgt - 12'd1;
    pts[PROBE_LEFT].x  = pos_x - char_lng - 12'd1;
    pts[PROBE_LEFT].y  = pos_y;
    pts[PROBE_RIGHT].x = pos_x + char_lng;
    pts[PROBE_RIGHT].y = pos_y;
  end

  // Frame start latches in either state; in SCAN that restarts a frame
  // whose vblnk never arrived, discarding its partial result.
  for (genvar i = 0; i < 4; i++) begin : g_pt
    vga_point_sampler #(.EDGE_SOLID(EDGE_SOLID)) u_pt (
      .clk         (clk),
      .rst_n       (rst_n),
      .latch       (frame_start),
      .sample_en   (sample_en),
      .pixel_solid (pixel_solid),
      .pt_next     (pts[i]),
      .hcount      (vga_in.hcount),
      .vcount      (vga_in.vcount),
      .result      (res[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_WAIT_FRAME;
      vblnk_q <= 1'b0;
    end else begin
      vblnk_q <= vga_in.vblnk;
      if (frame_start) begin
        state <= ST_SCAN;
      end else if (publish) begin
        state <= ST_WAIT_FRAME;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit       <= 4'b0000;
      hit_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (publish) begin
      hit       <= res;
      hit_valid <= 1'b1;
      if (hit_valid && !hit_ready) begin
        overrun <= 1'b1;
      end
    end else if (hit_valid && hit_ready) begin
      hit_valid <= 1'b0;
      overrun   <= 1'b0;
    end
  end

endmodule

// File: doc/vga_pixel_probe.md
Name: vga_pixel_probe

Overview:
- Passive reader of the composited VGA pixel stream. It samples the RGB value at four probe points around the character: below the feet, above the head, left of the body and right of the body.
- Once per frame it reports whether each point is solid (not background) to the game logic, using a valid/ready handshake.
- It taps the stream upstream of the character sprite drawer, so the character never collides with itself. It provides ground and wall detection for movement control.

Parameters:
- BG_RGB, 12'h6AF, background colour; any other sampled colour counts as solid.
- EDGE_SOLID, 1, value reported for a probe point lying outside the active area (screen border acts as a wall).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- pos_x  in  12  character centre x
- pos_y  in  12  character centre y
- char_hgt  in  12  sprite half-height (sprite spans rows pos_y-hgt .. pos_y+hgt-1)
- char_lng  in  12  sprite half-width (sprite spans columns pos_x-lng .. pos_x+lng-1)
- vga_in  vga_if.in  -  pixel stream (hcount, vcount, hblnk, vblnk, rgb); read only, no output stream
- hit  out  4  [0]=down, [1]=up, [2]=left, [3]=right; 1 = solid
- hit_valid  out  1  result available
- hit_ready  in  1  consumer accepts result
- overrun  out  1  an unaccepted result was overwritten

Behaviour:
- Reset (async, rst_n=0): hit=0, hit_valid=0, overrun=0, accumulators=0, FSM=WAIT_FRAME. A partial frame in progress is discarded.
- Frame start: cycle with vcount==0, hcount==0, !hblnk, !vblnk.
- Frame end: rising edge of vblnk, detected using a registered copy of vblnk.
- Probe coordinates, computed mod 4096 and latched at frame start (12-bit):
  - down = (pos_x, pos_y+hgt)
  - up = (pos_x, pos_y-hgt-1)
  - left = (pos_x-lng-1, pos_y)
  - right = (pos_x+lng, pos_y)
- Changes to pos/hgt/lng mid-frame do not affect the current scan.
- Off-screen rule: a probe is off-screen if x >= HOR_PIXELS or y >= VER_PIXELS (this also catches underflow wrap). Its result is EDGE_SOLID and its sampling is skipped.
- FSM WAIT_FRAME: idle until frame start, then latch probes, clear accumulators, go to SCAN. The first report after reset therefore always covers a whole frame.
- FSM SCAN:
  - On any active cycle where hcount/vcount (zero-extended) equal probe i: acc[i] <= (rgb != BG_RGB).
  - On frame end: publish result and go to WAIT_FRAME.
  - A frame start seen while still in SCAN (vblnk missing) re-latches probes and restarts the scan, publishing nothing.
- Publish (registered, result visible the cycle after the frame-end detect cycle):
  - hit <= acc, with off-screen bits forced to EDGE_SOLID; hit_valid <= 1.
  - If hit_valid was 1 and hit_ready was 0 in that cycle: overrun <= 1 and the old result is overwritten.
  - Publish with simultaneous accept (valid&ready): new result loads, hit_valid stays 1, overrun unchanged.
- Handshake:
  - hit and hit_valid stay stable while hit_valid=1 and hit_ready=0 (except on publish).
  - On valid&ready with no publish in that cycle: hit_valid <= 0, overrun <= 0; hit keeps its last value.
  - hit_ready while hit_valid=0 has no effect.
- Sampling latency: zero. The comparison uses vga_in.rgb in the same cycle as the matching hcount/vcount.

Decomposition:
- Shared game package:
  - probe_dir_e enum (PROBE_DOWN=0, PROBE_UP=1, PROBE_LEFT=2, PROBE_RIGHT=3)
  - BG colour constant
  - probe FSM state typedef
- HOR_PIXELS and VER_PIXELS come from vga_pkg.
- Sub-module vga_point_sampler: one coordinate comparator, off-screen check and accumulator bit, instantiated four times.

Test Plan:
- Reset: assert rst_n=0 at vcount=300, release -> hit=0, hit_valid=0, overrun=0. No hit_valid until the frame end of the first complete frame after release.
- Floor: pos=(400,500), hgt=26, lng=19, rgb=12'h840 for rows >=526, BG_RGB elsewhere -> hit=4'b0001 one cycle after the vblnk rise, held until hit_ready.
- Wall: solid column at x=419 only, same pos -> hit=4'b1000; with the column moved to x=418 -> hit=4'b0000.
- Edge: pos_x=10, lng=19 (left x wraps to 4086), all background:
  - EDGE_SOLID=1 -> hit=4'b0100
  - EDGE_SOLID=0 -> hit=4'b0000
- Backpressure: hit_ready=0 across two frame ends (floor in frame 1, none in frame 2):
  - after frame 2: overrun=1, hit=4'b0000
  - one-cycle hit_ready -> hit_valid=0, overrun=0
- Mid-frame move: pos changes from (400,500) to (100,200) at vcount=300 -> that frame's report reflects (400,500); the next frame's report reflects (100,200).
